dds_sin_ctrl: RTL and testbench

Direct-digital-synthesis controller that drives the sampler system's registered sine lookup ROM as its address initiator. It runs a phase accumulator advanced once per sample tick and issues the ROM address. It captures the ROM word one cycle later, scales it by a programmable amplitude and emits one signed sample per tick toward the DAC path. A small run/drain state machine starts and stops generation cleanly, so no partial samples escape.

---
 rtl/dds_sin_ctrl.sv | 111 +++++++++++
 tb/tb_dds_sin_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sin_ctrl.sv
// DDS controller: phase accumulator addressing a registered sine ROM, with
// amplitude scaling of the returned word and a run/drain control FSM.
module dds_sin_ctrl #(
    parameter int PW         = 30,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    input  logic [PW-1:0]         fccw,
    input  logic [PW-1:0]         poff,
    input  logic [DATA_WIDTH-1:0] amp,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  sample_valid,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q;
    logic [PW-1:0]           phase_q;
    logic [ADDR_WIDTH-1:0]   rom_addr_q;
    logic                    s1_q;
    logic                    s2_q;
    logic [DATA_WIDTH-1:0]   amp_s1_q;
    logic [DATA_WIDTH-1:0]   amp_s2_q;
    logic [DATA_WIDTH-1:0]   sample_q;
    logic                    sample_valid_q;

    logic                      accept;
    logic [PW-1:0]             addr_phase;
    logic [PW-1:0]             phase_d;
    logic [ADDR_WIDTH-1:0]     rom_addr_d;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic [DATA_WIDTH-1:0]     sample_d;

    // stop outranks a coincident tick, so that tick never enters the pipe
    assign accept     = (state_q == RUN) && tick && !stop;
    assign addr_phase = phase_q + poff;
    assign phase_d    = phase_q + fccw;
    assign rom_addr_d = ADDR_WIDTH'(addr_phase >> (PW - ADDR_WIDTH));

    // Q1.15 scaling; ROM never returns 0x8000, so the floor shift cannot overflow
    assign product  = $signed(rom_data) * $signed(amp_s2_q);
    assign sample_d = DATA_WIDTH'(product >>> (DATA_WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            rom_addr_q     <= '0;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            amp_s1_q       <= '0;
            amp_s2_q       <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        phase_q <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= DRAIN;
                    end else if (tick) begin
                        phase_q    <= phase_d;
                        rom_addr_q <= rom_addr_d;
                    end
                end
                DRAIN: begin
                    if (!s1_q && !s2_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            s1_q <= accept;
            if (accept) begin
                amp_s1_q <= amp;
            end
            s2_q     <= s1_q;
            amp_s2_q <= amp_s1_q;

            // rom_data for the stage-2 tick is on the bus during this cycle
            sample_valid_q <= s2_q;
            if (s2_q) begin
                sample_q <= sample_d;
            end
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dds_sin_ctrl.sv
// Scoreboard bench for dds_sin_ctrl with a registered sine ROM model.
module tb_dds_sin_ctrl;

    localparam int PW = 30;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          tick;
    logic [PW-1:0] fccw;
    logic [PW-1:0] poff;
    logic [DW-1:0] amp;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          busy;

    dds_sin_ctrl #(.PW(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .tick        (tick),
        .fccw        (fccw),
        .poff        (poff),
        .amp         (amp),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sample      (sample),
        .sample_valid(sample_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom_mem [0:255];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] smp;
        int            at;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_checks  = 0;
    int            n_fail    = 0;
    int            n_samples = 0;
    bit            running   = 1'b0;
    logic [PW-1:0] phase_m;
    logic [DW-1:0] last_push;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] scale(input logic [DW-1:0] d, input logic [DW-1:0] a);
        int p;
        p = $signed(d) * $signed(a);
        p = p >>> 15;
        return p[DW-1:0];
    endfunction

    // One clock cycle of stimulus; accepted ticks are predicted and queued.
    task automatic step(input logic tk, input logic st, input logic sp,
                        input bit has_k, input logic [DW-1:0] k);
        logic          acc;
        logic [PW-1:0] sum;
        logic [AW-1:0] ea;
        exp_t          e;
        tick  = tk;
        start = st;
        stop  = sp;
        acc   = running && tk && !sp;
        ea    = '0;
        if (acc) begin
            sum   = phase_m + poff;
            ea    = sum[PW-1:PW-AW];
            e.smp = has_k ? k : scale(rom_mem[ea], amp);
            e.at  = cyc + 3;
            sb.push_back(e);
            last_push = e.smp;
            phase_m   = phase_m + fccw;
        end
        if (st && !running) begin
            running = 1'b1;
            phase_m = '0;
        end
        if (sp && running) running = 1'b0;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        if (acc) chk("rom_addr", rom_addr, ea);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic tk_model();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic tk_const(input logic [DW-1:0] k);
        step(1'b1, 1'b0, 1'b0, 1'b1, k);
    endtask

    task automatic do_start();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic stop_drain();
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(5);
        chk("busy_after_drain", busy, 0);
    endtask

    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            n_samples++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", sample_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sample", sample, mon_e.smp);
                chk("latency", cyc, mon_e.at);
            end
        end
    end

    initial begin
        int  n0;
        real v;
        int  iv;
        for (int i = 0; i < 256; i++) begin
            v  = 32767.0 * $sin(2.0 * 3.14159265358979 * i / 256.0);
            iv = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            rom_mem[i] = iv[DW-1:0];
        end
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
        fccw  = '0;
        poff  = '0;
        amp   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_sample", sample, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        idle(2);

        // Basic sweep, tick every 4 cycles
        amp  = 16'h4000;
        fccw = 30'(1 << 22);
        poff = '0;
        do_start();
        chk("busy_run", busy, 1);
        for (int i = 0; i < 200; i++) begin
            if (i == 0)        tk_const(16'h0000);
            else if (i == 1)   tk_const(16'h0192);
            else if (i == 64)  tk_const(16'h3FFF);
            else if (i == 192) tk_const(16'hC000);
            else               tk_model();
            idle(3);
        end
        stop_drain();
        chk("sample_hold", sample, {16'h0, last_push});

        // Back-to-back for 300 cycles, rom_addr wraps
        do_start();
        n0 = n_samples;
        for (int i = 0; i < 300; i++) tk_model();
        stop_drain();
        chk("b2b_count", n_samples - n0, 300);

        // Quarter-turn offset at full amplitude
        poff = 30'(1 << 28);
        amp  = 16'h7FFF;
        do_start();
        tk_const(16'h7FFE);
        tk_model();
        stop_drain();

        // Negative increment: addresses 0, 255, 254
        poff = '0;
        fccw = 30'((1 << 30) - (1 << 22));
        do_start();
        for (int i = 0; i < 3; i++) tk_model();
        stop_drain();

        // Amplitude extremes, parameters changing per tick
        fccw = '0;
        do_start();
        amp  = 16'h8000;
        poff = 30'(3 << 28);
        tk_const(16'h7FFF);
        poff = 30'(1 << 28);
        tk_const(16'h8001);
        amp  = 16'h0000;
        fccw = 30'(1 << 22);
        for (int i = 0; i < 6; i++) tk_const(16'h0000);
        amp  = 16'h4000;
        tk_model();
        stop_drain();

        // Stop together with a tick: that tick is dropped
        do_start();
        n0 = n_samples;
        tk_model();
        tk_model();
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        chk("drain_busy_t3", busy, 1);
        idle(1);
        chk("drain_busy_t4", busy, 1);
        idle(1);
        chk("drain_busy_t5", busy, 0);
        chk("drain_count", n_samples - n0, 2);
        idle(2);

        // Reset one cycle after a tick
        fccw = 30'(1 << 24);
        do_start();
        tk_model();
        tk_model();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", sample_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", rom_addr, 0);
        chk("mid_rst_sample", sample, 0);
        sb.delete();
        running = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(6);
        fccw = 30'(1 << 22);
        do_start();
        tk_model();
        tk_model();
        stop_drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
